// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state type and access-size helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP} lsu_state_t;

    // Low two funct3 bits encode size for both signed and unsigned loads.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            2'b10:   size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic legal_op(input logic store, input logic [2:0] f3);
        legal_op = store ? (!f3[2] && f3[1:0] != 2'b11) : (f3[1:0] != 2'b11 && f3 != 3'b110);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: store-side lane shifting/masking and load-side extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [63:0] rbuf,
    output logic [63:0] sdata,
    output logic [7:0]  mask,
    output logic [31:0] rdata
);

    logic [63:0] shifted;

    always_comb begin
        sdata   = {32'b0, wdata} << {off, 3'b000};
        mask    = {4'b0, size_mask(funct3)} << off;
        shifted = rbuf >> {off, 3'b000};
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   rdata = {24'b0, shifted[7:0]};
            F3_HU:   rdata = {16'b0, shifted[15:0]};
            default: rdata = shifted[31:0];
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding data-memory initiator; splits word-crossing accesses into two beats.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_t            state, next;
    logic                  store_q, err_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q, word_addr;
    logic [DATA_WIDTH-1:0] wdata_q, rdata;
    logic [63:0]           rbuf, sdata;
    logic [7:0]            mask;
    logic                  split;

    lsu_align u_align (
        .funct3(f3_q),
        .off   (addr_q[1:0]),
        .wdata (wdata_q),
        .rbuf  (rbuf),
        .sdata (sdata),
        .mask  (mask),
        .rdata (rdata)
    );

    assign split     = |mask[7:4];
    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        next      = state;
        req_ready = state == IDLE;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0;
        mem_wdata = '0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        case (state)
            IDLE: if (req_valid) next = legal_op(req_store, req_funct3) ? REQ1 : RESP;
            REQ1: begin
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = word_addr;
                mem_be    = mask[3:0];
                mem_wdata = store_q ? sdata[31:0] : '0;
                if (mem_gnt) next = !store_q ? WAIT1 : (split ? REQ2 : RESP);
            end
            WAIT1: if (mem_rvalid) next = split ? REQ2 : RESP;
            REQ2: begin
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = word_addr + ADDR_WIDTH'(4);
                mem_be    = mask[7:4];
                mem_wdata = store_q ? sdata[63:32] : '0;
                if (mem_gnt) next = store_q ? RESP : WAIT2;
            end
            WAIT2: if (mem_rvalid) next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_data  = (err_q || store_q) ? '0 : rdata;
                next      = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf    <= 64'b0;
        end else begin
            state <= next;
            if (state == IDLE && req_valid) begin
                store_q <= req_store;
                err_q   <= !legal_op(req_store, req_funct3);
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == WAIT1 && mem_rvalid) rbuf[31:0] <= mem_rdata;
            if (state == WAIT2 && mem_rvalid) rbuf[63:32] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus reset-abandon sequence for load_store_unit.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, mem_req, mem_we;
    logic [31:0] rsp_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] st, f3, addr, wdata, r1, r2, gdly, beats;
        logic [31:0] a1, b1, w1, a2, b2, w2, rd, err, lat;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run(input int id, input vec_t v);
        int beat = 0;
        int stall = 0;
        int c;
        logic pend = 1'b0;
        logic done = 1'b0;
        logic [31:0] pdata = '0;
        @(negedge clk);
        chk($sformatf("v%0d ready_idle", id), 32'(req_ready), 1);
        req_valid  = 1'b1;
        req_store  = v.st[0];
        req_funct3 = v.f3[2:0];
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        for (c = 1; c <= 30 && !done; c++) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pdata;
                pend       = 1'b0;
            end
            if (rsp_valid) begin
                chk($sformatf("v%0d latency", id), 32'(c), v.lat);
                chk($sformatf("v%0d rsp_data", id), rsp_data, v.rd);
                chk($sformatf("v%0d rsp_err", id), 32'(rsp_err), v.err);
                chk($sformatf("v%0d beats", id), 32'(beat), v.beats);
                chk($sformatf("v%0d req_resp", id), 32'(mem_req), 0);
                done = 1'b1;
            end else begin
                chk($sformatf("v%0d ready_busy", id), 32'(req_ready), 0);
                if (mem_req) begin
                    chk($sformatf("v%0d req_expected", id), 32'(mem_req), 32'(beat < int'(v.beats)));
                    chk($sformatf("v%0d addr%0d", id, beat), mem_addr, beat == 0 ? v.a1 : v.a2);
                    chk($sformatf("v%0d be%0d", id, beat), 32'(mem_be), beat == 0 ? v.b1 : v.b2);
                    chk($sformatf("v%0d wdata%0d", id, beat), mem_wdata, beat == 0 ? v.w1 : v.w2);
                    chk($sformatf("v%0d we%0d", id, beat), 32'(mem_we), v.st);
                    if (stall < int'(v.gdly)) stall++;
                    else begin
                        mem_gnt = 1'b1;
                        if (!v.st[0]) begin
                            pend  = 1'b1;
                            pdata = beat == 0 ? v.r1 : v.r2;
                        end
                        beat++;
                    end
                end
            end
            if (!done) @(negedge clk);
        end
        chk($sformatf("v%0d timeout", id), 32'(done), 1);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        //        st f3 addr          wdata         r1            r2            gd bt a1            b1     w1            a2       b2     w2     rd            er lat
        vt[0]  = '{0, 2, 'h100,       0,            'hDEADBEEF,   0,            0, 1, 'h100,        'hF,   0,            0,       0,     0,     'hDEADBEEF,   0, 3};
        vt[1]  = '{0, 0, 'h103,       0,            'h80FFFFFF,   0,            0, 1, 'h100,        'h8,   0,            0,       0,     0,     'hFFFFFF80,   0, 3};
        vt[2]  = '{0, 4, 'h103,       0,            'h80FFFFFF,   0,            0, 1, 'h100,        'h8,   0,            0,       0,     0,     'h00000080,   0, 3};
        vt[3]  = '{1, 1, 'h0FF,       'hABCD,       0,            0,            0, 2, 'h0FC,        'h8,   'hCD000000,   'h100,   'h1,   'hAB,  0,            0, 3};
        vt[4]  = '{0, 2, 'h102,       0,            'h33445566,   'h77881122,   0, 2, 'h100,        'hC,   0,            'h104,   'h3,   0,     'h11223344,   0, 5};
        vt[5]  = '{1, 2, 'h200,       'h12345678,   0,            0,            0, 1, 'h200,        'hF,   'h12345678,   0,       0,     0,     0,            0, 2};
        vt[6]  = '{0, 1, 'h102,       0,            'h80010000,   0,            0, 1, 'h100,        'hC,   0,            0,       0,     0,     'hFFFF8001,   0, 3};
        vt[7]  = '{0, 5, 'h101,       0,            'h00BEEF00,   0,            0, 1, 'h100,        'h6,   0,            0,       0,     0,     'h0000BEEF,   0, 3};
        vt[8]  = '{1, 0, 'h003,       'h5A,         0,            0,            0, 1, 'h000,        'h8,   'h5A000000,   0,       0,     0,     0,            0, 2};
        vt[9]  = '{1, 3, 'h040,       'h1,          0,            0,            0, 0, 0,            0,     0,            0,       0,     0,     0,            1, 1};
        vt[10] = '{0, 6, 'h044,       0,            0,            0,            0, 0, 0,            0,     0,            0,       0,     0,     0,            1, 1};
        vt[11] = '{0, 2, 'hFFFFFFFE,  0,            'h22220000,   'h00004444,   0, 2, 'hFFFFFFFC,   'hC,   0,            'h0,     'h3,   0,     'h44442222,   0, 5};
        vt[12] = '{0, 1, 'h103,       0,            'hFE000000,   'h000000FF,   0, 2, 'h100,        'h8,   0,            'h104,   'h1,   0,     'hFFFFFFFE,   0, 5};
        vt[13] = '{1, 2, 'h204,       'hCAFEF00D,   0,            0,            5, 1, 'h204,        'hF,   'hCAFEF00D,   0,       0,     0,     0,            0, 7};
        vt[14] = '{1, 0, 'h001,       'h77,         0,            0,            0, 1, 'h000,        'h2,   'h00007700,   0,       0,     0,     0,            0, 2};

        #12;
        chk("rst req_ready", 32'(req_ready), 1);
        chk("rst mem_req", 32'(mem_req), 0);
        chk("rst rsp_valid", 32'(rsp_valid), 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_be", 32'(mem_be), 0);
        chk("rst rsp_data", rsp_data, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run(i, vt[i]);

        // Reset while a read is pending: the late rvalid must not produce a response.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 'h300;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort mem_req", 32'(mem_req), 1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("abort in_wait", 32'(mem_req | req_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("abort rst ready", 32'(req_ready), 1);
        chk("abort rst mem_req", 32'(mem_req), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 'h55AA55AA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("abort no_rsp%0d", k), 32'(rsp_valid), 0);
            chk($sformatf("abort idle%0d", k), 32'(req_ready), 1);
            @(negedge clk);
        end

        run(99, vt[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Core-side initiator for data-memory accesses; the requesting end of the load/store interface that the data memory serves.
- Accepts one load/store from the execute stage, drives word-aligned byte-enabled memory requests, and returns sign/zero-extended load data.
- Splits word-crossing misaligned accesses into two word transactions. One transaction outstanding at a time.
- Sits between the pipeline MEM stage and the data memory port.

Parameters:
- ADDR_WIDTH, 32, byte address width on core and memory sides.
- DATA_WIDTH, 32, data width; fixed at 32, byte lanes = 4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  instruction bits 14:12.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  illegal funct3; qualified by rsp_valid.
- mem_req  out  1  memory request.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_WIDTH  word-aligned address, bits 1:0 = 0.
- mem_be  out  4  byte enables, bit i = byte lane i.
- mem_wdata  out  DATA_WIDTH  lane-positioned write data.
- mem_gnt  in  1  memory accepts the current request.
- mem_rvalid  in  1  read data valid; at least one cycle after gnt.
- mem_rdata  in  DATA_WIDTH  read word.

Behaviour:
- Reset (async, rst_n=0): state IDLE. req_ready=1. rsp_valid, rsp_err, mem_req and mem_we = 0. rsp_data, mem_addr, mem_be and mem_wdata = 0. Any in-flight request is abandoned; a late mem_rvalid after reset is ignored.
- Handshake: a request is accepted when req_valid&req_ready. req_ready=1 only in IDLE. All request fields are registered at acceptance.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal: go to RESP with rsp_err=1, no memory access.
- Access size: 1, 2 or 4 bytes; off = addr[1:0]. Split when off + size > 4.
- Store lanes: 64-bit shifted data = wdata << (8*off); 8-bit mask = sizemask << off.
  - First beat uses the low 32 bits and mask[3:0] at {addr[31:2],00}.
  - Second beat uses the high 32 bits and mask[7:4] at first address + 4, wrapping modulo 2^ADDR_WIDTH.
- Load assembly: the first beat fills the low word and the second beat the high word of a 64-bit buffer. Result = buffer >> (8*off), truncated to size. Sign extension for LB/LH; zero extension for LBU/LHU.
- Loads drive mem_be with the same mask as stores. mem_wdata = 0 on loads.
- States:
  - IDLE: on accept, go to REQ1 (legal) or RESP (illegal).
  - REQ1: mem_req=1 with fields held stable until mem_gnt. On gnt:
    - load, go to WAIT1;
    - store, go to REQ2 if split, else RESP.
  - WAIT1: mem_req=0. On mem_rvalid, capture data, then go to REQ2 if split, else RESP.
  - REQ2 and WAIT2: same as REQ1 and WAIT1 for the second beat, then RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready stays 0 during RESP.
- Latency, aligned load with gnt in the first REQ cycle and rvalid one cycle later: accept at T, mem_req at T+1, rvalid at T+2, rsp_valid at T+3.
- Latency, aligned store with immediate gnt: rsp_valid at T+2.
- mem_req never asserts for two transactions in the same cycle. No new mem_req before the pending read returns.
- mem_rvalid outside WAIT1/WAIT2 is ignored. mem_gnt while mem_req=0 is ignored.

Decomposition:
- lsu_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum lsu_state_t (IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP);
  - size-to-mask function.
- One combinational sub-module, lsu_align:
  - store side: computes the 64-bit shifted data and 8-bit mask from wdata, funct3 and off;
  - load side: extracts and extends the result from the 64-bit buffer.
- The FSM and registers stay in load_store_unit.

Test Plan:
- LW at addr 0x100, mem returns 0xDEADBEEF with gnt immediate and rvalid +1 -> one beat, mem_addr=0x100, be=1111, rsp_data=0xDEADBEEF, rsp_valid at T+3.
- LB at 0x103 with rdata 0x80FFFFFF -> be=1000, rsp_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x0FF, wdata=0x0000ABCD -> beat 1: addr 0x0FC, be=1000, wdata=0xCD000000. Beat 2: addr 0x100, be=0001, wdata=0x000000AB. rsp_err=0.
- LW at 0x102, beats return 0x3344xxxx then 0xxxxx1122 -> two read beats at 0x100 and 0x104, rsp_data=0x11223344.
- mem_gnt held low 5 cycles in REQ1 -> mem_req, mem_addr, mem_be and mem_wdata stable throughout, req_ready=0.
- Store with funct3=011 -> no mem_req, rsp_valid pulse with rsp_err=1. Separately, rst_n low during WAIT1, then a late rvalid -> state IDLE, no rsp_valid.
